// File: rtl/wb_dcache_evict_buffer.sv
// Write-back eviction buffer: queues dirty cache lines, drains them to memory over a
// req/ack port, and lets cache misses read lines still waiting in the queue.
module wb_dcache_evict_buffer #(
    parameter int DEPTH       = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int OFFSET_BITS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         evict_req_i,
    input  logic [ADDR_WIDTH-1:0]        evict_addr_i,
    input  logic [LINE_WIDTH-1:0]        evict_data_i,
    output logic                         evict_ready_o,
    input  logic                         lookup_req_i,
    input  logic [ADDR_WIDTH-1:0]        lookup_addr_i,
    output logic                         lookup_hit_o,
    output logic [LINE_WIDTH-1:0]        lookup_data_o,
    output logic                         mem_wr_req_o,
    output logic [ADDR_WIDTH-1:0]        mem_wr_addr_o,
    output logic [LINE_WIDTH-1:0]        mem_wr_data_o,
    input  logic                         mem_wr_ack_i,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t                  state_r;
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        count_r;
    logic [CNT_W-1:0]        count_next_s;
    logic [DEPTH-1:0]        valid_r;
    logic [ADDR_WIDTH-1:0]   addr_mem_r [DEPTH];
    logic [LINE_WIDTH-1:0]   data_mem_r [DEPTH];
    logic                    push_s;
    logic                    pop_s;
    logic [DEPTH-1:0]        match_s;
    logic                    hit_s;
    logic [LINE_WIDTH-1:0]   hit_data_s;

    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
        line_align = addr & LINE_MASK;
    endfunction

    assign evict_ready_o = (count_r != CNT_W'(DEPTH));
    assign push_s        = evict_req_i && evict_ready_o;
    assign pop_s         = (state_r == REQ) && mem_wr_ack_i;
    assign empty_o       = (count_r == CNT_W'(0));
    assign count_o       = count_r;
    assign mem_wr_req_o  = (state_r == REQ);
    assign mem_wr_addr_o = mem_wr_req_o ? addr_mem_r[rd_ptr_r] : {ADDR_WIDTH{1'b0}};
    assign mem_wr_data_o = mem_wr_req_o ? data_mem_r[rd_ptr_r] : {LINE_WIDTH{1'b0}};
    assign lookup_hit_o  = lookup_req_i && hit_s;
    assign lookup_data_o = lookup_hit_o ? hit_data_s : {LINE_WIDTH{1'b0}};

    // Next occupancy from the push/pop combination.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy, valid bits and the drain FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
                valid_r[wr_ptr_r] <= 1'b1;
            end
            // A push never lands on the head slot while it is being popped.
            if (pop_s) begin
                rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
                valid_r[rd_ptr_r] <= 1'b0;
            end
            count_r <= count_next_s;
            case (state_r)
                IDLE:    state_r <= (count_next_s != CNT_W'(0)) ? REQ : IDLE;
                REQ:     state_r <= (pop_s && (count_next_s == CNT_W'(0))) ? IDLE : REQ;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Line storage; guarded by valid_r so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem_r[wr_ptr_r] <= line_align(evict_addr_i);
            data_mem_r[wr_ptr_r] <= evict_data_i;
        end
    end

    // Line-address compare against every live entry.
    always_comb begin
        match_s = '0;
        for (int j = 0; j < DEPTH; j++) begin
            match_s[j] = valid_r[j] && (addr_mem_r[j] == line_align(lookup_addr_i));
        end
    end

    // Walk from oldest to newest so the most recent re-eviction of a line wins.
    always_comb begin
        hit_s      = 1'b0;
        hit_data_s = {LINE_WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (match_s[rd_ptr_r + PTR_W'(i)]) begin
                hit_s      = 1'b1;
                hit_data_s = data_mem_r[rd_ptr_r + PTR_W'(i)];
            end else begin
                hit_s      = hit_s;
            end
        end
    end

endmodule

// File: tb/tb_wb_dcache_evict_buffer.sv
// Directed bench for wb_dcache_evict_buffer: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_wb_dcache_evict_buffer;

    logic         clk;
    logic         rst_n;
    logic         evict_req_i;
    logic [31:0]  evict_addr_i;
    logic [127:0] evict_data_i;
    logic         evict_ready_o;
    logic         lookup_req_i;
    logic [31:0]  lookup_addr_i;
    logic         lookup_hit_o;
    logic [127:0] lookup_data_o;
    logic         mem_wr_req_o;
    logic [31:0]  mem_wr_addr_o;
    logic [127:0] mem_wr_data_o;
    logic         mem_wr_ack_i;
    logic         empty_o;
    logic [2:0]   count_o;

    int checks;
    int passed;

    wb_dcache_evict_buffer #(
        .DEPTH(4), .ADDR_WIDTH(32), .LINE_WIDTH(128), .OFFSET_BITS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .evict_req_i(evict_req_i), .evict_addr_i(evict_addr_i),
        .evict_data_i(evict_data_i), .evict_ready_o(evict_ready_o),
        .lookup_req_i(lookup_req_i), .lookup_addr_i(lookup_addr_i),
        .lookup_hit_o(lookup_hit_o), .lookup_data_o(lookup_data_o),
        .mem_wr_req_o(mem_wr_req_o), .mem_wr_addr_o(mem_wr_addr_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_wr_ack_i(mem_wr_ack_i),
        .empty_o(empty_o), .count_o(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [127:0] d);
        evict_req_i  = 1'b1;
        evict_addr_i = a;
        evict_data_i = d;
        tick();
        evict_req_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        lookup_req_i  = 1'b1;
        lookup_addr_i = 32'h0000_0000;
        #1;
        checks++; if (evict_ready_o !== 1'b1) $display("FAIL reset_ready: got %b exp 1", evict_ready_o); else passed++;
        checks++; if (mem_wr_req_o !== 1'b0) $display("FAIL reset_req: got %b exp 0", mem_wr_req_o); else passed++;
        checks++; if (mem_wr_addr_o !== 32'h0) $display("FAIL reset_addr: got %h exp 0", mem_wr_addr_o); else passed++;
        checks++; if (mem_wr_data_o !== 128'h0) $display("FAIL reset_data: got %h exp 0", mem_wr_data_o); else passed++;
        checks++; if (lookup_hit_o !== 1'b0 || lookup_data_o !== 128'h0) $display("FAIL reset_lookup: got hit %b data %h exp 0/0", lookup_hit_o, lookup_data_o); else passed++;
        checks++; if (empty_o !== 1'b1 || count_o !== 3'd0) $display("FAIL reset_empty_count: got %b/%0d exp 1/0", empty_o, count_o); else passed++;
        lookup_req_i = 1'b0;
    endtask

    task automatic test_single_line();
        push(32'h0000_1234, {16{8'hA5}});
        checks++; if (mem_wr_req_o !== 1'b1) $display("FAIL single_req: got %b exp 1", mem_wr_req_o); else passed++;
        checks++; if (mem_wr_addr_o !== 32'h0000_1230) $display("FAIL single_addr: got %h exp 00001230", mem_wr_addr_o); else passed++;
        checks++; if (mem_wr_data_o !== {16{8'hA5}}) $display("FAIL single_data: got %h exp a5..a5", mem_wr_data_o); else passed++;
        checks++; if (count_o !== 3'd1 || empty_o !== 1'b0) $display("FAIL single_count: got %0d/%b exp 1/0", count_o, empty_o); else passed++;
        tick();
        tick();
        checks++; if (mem_wr_req_o !== 1'b1 || mem_wr_addr_o !== 32'h0000_1230) $display("FAIL single_hold: got %b/%h exp 1/00001230", mem_wr_req_o, mem_wr_addr_o); else passed++;
        mem_wr_ack_i = 1'b1;
        tick();
        mem_wr_ack_i = 1'b0;
        checks++; if (count_o !== 3'd0 || empty_o !== 1'b1) $display("FAIL single_drain: got %0d/%b exp 0/1", count_o, empty_o); else passed++;
        checks++; if (mem_wr_req_o !== 1'b0 || mem_wr_addr_o !== 32'h0) $display("FAIL single_req_drop: got %b/%h exp 0/0", mem_wr_req_o, mem_wr_addr_o); else passed++;
    endtask

    task automatic test_fill();
        logic [31:0]  exp_a [4];
        logic [127:0] exp_d [4];
        for (int i = 0; i < 4; i++) push(32'h0000_1000 * (i + 1), {4{32'h1111_0000 + 32'(i)}});
        checks++; if (evict_ready_o !== 1'b0 || count_o !== 3'd4) $display("FAIL fill_full: got %b/%0d exp 0/4", evict_ready_o, count_o); else passed++;
        evict_req_i  = 1'b1;
        evict_addr_i = 32'h0000_5000;
        evict_data_i = {4{32'h1111_0004}};
        tick();
        checks++; if (count_o !== 3'd4 || mem_wr_addr_o !== 32'h0000_1000) $display("FAIL fill_ignore: got %0d/%h exp 4/00001000", count_o, mem_wr_addr_o); else passed++;
        mem_wr_ack_i = 1'b1;
        tick();
        mem_wr_ack_i = 1'b0;
        checks++; if (evict_ready_o !== 1'b1 || count_o !== 3'd3) $display("FAIL fill_ack_ready: got %b/%0d exp 1/3", evict_ready_o, count_o); else passed++;
        tick();
        evict_req_i = 1'b0;
        checks++; if (count_o !== 3'd4) $display("FAIL fill_fifth_push: got %0d exp 4", count_o); else passed++;
        for (int i = 0; i < 4; i++) begin
            exp_a[i] = 32'h0000_1000 * (i + 2);
            exp_d[i] = {4{32'h1111_0001 + 32'(i)}};
        end
        mem_wr_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_wr_addr_o !== exp_a[i] || mem_wr_data_o !== exp_d[i]) $display("FAIL fill_order_%0d: got %h/%h exp %h/%h", i, mem_wr_addr_o, mem_wr_data_o, exp_a[i], exp_d[i]); else passed++;
            tick();
        end
        mem_wr_ack_i = 1'b0;
        checks++; if (empty_o !== 1'b1 || mem_wr_req_o !== 1'b0) $display("FAIL fill_drained: got %b/%b exp 1/0", empty_o, mem_wr_req_o); else passed++;
    endtask

    task automatic test_back_to_back();
        push(32'h0000_0600, {4{32'hB1B1_B1B1}});
        push(32'h0000_0700, {4{32'hB2B2_B2B2}});
        checks++; if (count_o !== 3'd2 || mem_wr_addr_o !== 32'h0000_0600) $display("FAIL b2b_setup: got %0d/%h exp 2/00000600", count_o, mem_wr_addr_o); else passed++;
        mem_wr_ack_i = 1'b1;
        push(32'h0000_0800, {4{32'hB3B3_B3B3}});
        mem_wr_ack_i = 1'b0;
        checks++; if (count_o !== 3'd2 || mem_wr_req_o !== 1'b1) $display("FAIL b2b_count: got %0d/%b exp 2/1", count_o, mem_wr_req_o); else passed++;
        checks++; if (mem_wr_addr_o !== 32'h0000_0700 || mem_wr_data_o !== {4{32'hB2B2_B2B2}}) $display("FAIL b2b_next_head: got %h/%h exp 00000700/b2..", mem_wr_addr_o, mem_wr_data_o); else passed++;
        mem_wr_ack_i = 1'b1;
        tick();
        checks++; if (mem_wr_addr_o !== 32'h0000_0800 || mem_wr_data_o !== {4{32'hB3B3_B3B3}}) $display("FAIL b2b_third: got %h/%h exp 00000800/b3..", mem_wr_addr_o, mem_wr_data_o); else passed++;
        tick();
        mem_wr_ack_i = 1'b0;
        checks++; if (empty_o !== 1'b1) $display("FAIL b2b_empty: got %b exp 1", empty_o); else passed++;
    endtask

    task automatic test_lookup();
        push(32'h0000_0100, {4{32'hD1D1_D1D1}});
        push(32'h0000_0200, {4{32'hD2D2_D2D2}});
        lookup_req_i  = 1'b1;
        lookup_addr_i = 32'h0000_0208;
        #1;
        checks++; if (lookup_hit_o !== 1'b1 || lookup_data_o !== {4{32'hD2D2_D2D2}}) $display("FAIL lookup_hit: got %b/%h exp 1/d2..", lookup_hit_o, lookup_data_o); else passed++;
        lookup_addr_i = 32'h0000_0300;
        #1;
        checks++; if (lookup_hit_o !== 1'b0 || lookup_data_o !== 128'h0) $display("FAIL lookup_miss: got %b/%h exp 0/0", lookup_hit_o, lookup_data_o); else passed++;
        lookup_req_i  = 1'b0;
        lookup_addr_i = 32'h0000_0208;
        #1;
        checks++; if (lookup_hit_o !== 1'b0 || lookup_data_o !== 128'h0) $display("FAIL lookup_noreq: got %b/%h exp 0/0", lookup_hit_o, lookup_data_o); else passed++;
        lookup_req_i  = 1'b1;
        lookup_addr_i = 32'h0000_0104;
        mem_wr_ack_i  = 1'b1;
        #1;
        checks++; if (lookup_hit_o !== 1'b1 || lookup_data_o !== {4{32'hD1D1_D1D1}}) $display("FAIL lookup_ack_cycle: got %b/%h exp 1/d1..", lookup_hit_o, lookup_data_o); else passed++;
        tick();
        mem_wr_ack_i = 1'b0;
        checks++; if (lookup_hit_o !== 1'b0) $display("FAIL lookup_after_pop: got %b exp 0", lookup_hit_o); else passed++;
        lookup_req_i = 1'b0;
        mem_wr_ack_i = 1'b1;
        tick();
        mem_wr_ack_i = 1'b0;
    endtask

    task automatic test_duplicate();
        lookup_req_i  = 1'b1;
        lookup_addr_i = 32'h0000_0404;
        evict_req_i   = 1'b1;
        evict_addr_i  = 32'h0000_0400;
        evict_data_i  = {4{32'hE1E1_E1E1}};
        #1;
        checks++; if (lookup_hit_o !== 1'b0) $display("FAIL dup_same_cycle_push: got %b exp 0", lookup_hit_o); else passed++;
        tick();
        evict_data_i = {4{32'hE2E2_E2E2}};
        #1;
        checks++; if (lookup_hit_o !== 1'b1 || lookup_data_o !== {4{32'hE1E1_E1E1}}) $display("FAIL dup_first: got %b/%h exp 1/e1..", lookup_hit_o, lookup_data_o); else passed++;
        tick();
        evict_req_i = 1'b0;
        checks++; if (lookup_hit_o !== 1'b1 || lookup_data_o !== {4{32'hE2E2_E2E2}}) $display("FAIL dup_newest: got %b/%h exp 1/e2..", lookup_hit_o, lookup_data_o); else passed++;
        lookup_req_i = 1'b0;
        checks++; if (mem_wr_addr_o !== 32'h0000_0400 || mem_wr_data_o !== {4{32'hE1E1_E1E1}}) $display("FAIL dup_mem_first: got %h/%h exp 00000400/e1..", mem_wr_addr_o, mem_wr_data_o); else passed++;
        mem_wr_ack_i = 1'b1;
        tick();
        checks++; if (mem_wr_data_o !== {4{32'hE2E2_E2E2}}) $display("FAIL dup_mem_second: got %h exp e2..", mem_wr_data_o); else passed++;
        tick();
        mem_wr_ack_i = 1'b0;
        checks++; if (empty_o !== 1'b1) $display("FAIL dup_empty: got %b exp 1", empty_o); else passed++;
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) push(32'h0000_A000 + 32'h100 * i, {4{32'hC0C0_0000 + 32'(i)}});
        checks++; if (count_o !== 3'd3 || mem_wr_req_o !== 1'b1) $display("FAIL rstmid_setup: got %0d/%b exp 3/1", count_o, mem_wr_req_o); else passed++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        lookup_req_i  = 1'b1;
        lookup_addr_i = 32'h0000_A000;
        #1;
        checks++; if (mem_wr_req_o !== 1'b0 || count_o !== 3'd0 || empty_o !== 1'b1) $display("FAIL rstmid_state: got %b/%0d/%b exp 0/0/1", mem_wr_req_o, count_o, empty_o); else passed++;
        checks++; if (lookup_hit_o !== 1'b0) $display("FAIL rstmid_lookup: got %b exp 0", lookup_hit_o); else passed++;
        lookup_req_i = 1'b0;
        push(32'h0000_9008, {4{32'h9999_9999}});
        checks++; if (mem_wr_req_o !== 1'b1 || mem_wr_addr_o !== 32'h0000_9000 || count_o !== 3'd1) $display("FAIL rstmid_repush: got %b/%h/%0d exp 1/00009000/1", mem_wr_req_o, mem_wr_addr_o, count_o); else passed++;
        mem_wr_ack_i = 1'b1;
        tick();
        mem_wr_ack_i = 1'b0;
        checks++; if (empty_o !== 1'b1 || mem_wr_req_o !== 1'b0) $display("FAIL rstmid_drain: got %b/%b exp 1/0", empty_o, mem_wr_req_o); else passed++;
    endtask

    initial begin
        checks        = 0;
        passed        = 0;
        rst_n         = 1'b0;
        evict_req_i   = 1'b0;
        evict_addr_i  = 32'h0;
        evict_data_i  = 128'h0;
        lookup_req_i  = 1'b0;
        lookup_addr_i = 32'h0;
        mem_wr_ack_i  = 1'b0;
        test_reset();
        test_single_line();
        test_fill();
        test_back_to_back();
        test_lookup();
        test_duplicate();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/wb_dcache_evict_buffer.md
Name: wb_dcache_evict_buffer

Overview:
- Write-back buffer sitting directly downstream of the write-back data cache datapath.
- Accepts dirty 128-bit lines evicted by the cache, queues them in a small FIFO, and drains them to the data memory write port using a req/ack handshake.
- While a line is queued, a cache miss to that line is serviced from the buffer through an associative lookup, so stale memory data is never allocated.
- The empty flag gates flush and fence completion in the cache controller.

Parameters:
- DEPTH, 4, number of line entries (power of two, >= 2)
- ADDR_WIDTH, 32, byte address width
- LINE_WIDTH, 128, cache line width in bits
- OFFSET_BITS, 4, line offset bits (log2 of line bytes)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- evict_req_i  input  1  push request for a dirty line
- evict_addr_i  input  ADDR_WIDTH  line address of evicted line
- evict_data_i  input  LINE_WIDTH  evicted line data
- evict_ready_o  output  1  buffer can accept a push this cycle
- lookup_req_i  input  1  miss lookup request
- lookup_addr_i  input  ADDR_WIDTH  miss address
- lookup_hit_o  output  1  lookup matched a queued line
- lookup_data_o  output  LINE_WIDTH  matched line data
- mem_wr_req_o  output  1  memory write request
- mem_wr_addr_o  output  ADDR_WIDTH  memory write line address
- mem_wr_data_o  output  LINE_WIDTH  memory write line data
- mem_wr_ack_i  input  1  memory accepted current write
- empty_o  output  1  no entries queued
- count_o  output  $clog2(DEPTH+1)  number of queued entries

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk.
  - Reset clears pointers, count, per-entry valid bits and the FSM (to IDLE).
  - Entry data storage is not reset.
  - Output values after reset: evict_ready_o=1, mem_wr_req_o=0, mem_wr_addr_o=0, mem_wr_data_o=0, lookup_hit_o=0, lookup_data_o=0, empty_o=1, count_o=0.
- Storage:
  - Circular FIFO with wrapping write/read pointers.
  - The address is stored with bits [OFFSET_BITS-1:0] forced to zero.
  - Each entry has a valid bit, set on push and cleared on pop.
- Push:
  - Occurs when evict_req_i && evict_ready_o. evict_ready_o = (count_o != DEPTH); it is not dependent on a same-cycle ack.
  - A push while full is ignored (no state change). Upstream must hold the request until ready.
- Drain FSM, states IDLE and REQ:
  - IDLE -> REQ when count != 0 (registered decision), so the first mem_wr_req_o is asserted the cycle after the push edge.
  - In REQ: mem_wr_req_o=1, and mem_wr_addr_o/mem_wr_data_o come from the head entry, held stable until ack.
  - On mem_wr_ack_i in REQ: pop the head. Stay in REQ if entries remain after the pop (including a same-cycle push). Otherwise go to IDLE.
  - Back-to-back acks drain one entry per cycle.
  - mem_wr_ack_i is ignored while in IDLE.
  - mem_wr_addr_o and mem_wr_data_o are zero whenever mem_wr_req_o=0.
- Count:
  - Push only: +1. Pop only: -1. Push and pop together: unchanged, with both pointers advancing.
  - empty_o = (count==0).
- Lookup (combinational, same cycle):
  - Compares lookup_addr_i[ADDR_WIDTH-1:OFFSET_BITS] against every valid entry.
  - When several entries match (a line re-dirtied and re-evicted), the newest entry wins, ordered by age from the read pointer.
  - The head entry is searchable up to and including the cycle its ack arrives.
  - A push in the current cycle is visible to lookup only from the next cycle.
  - lookup_hit_o=0 and lookup_data_o=0 when lookup_req_i=0 or no entry matches.
- Lookup never modifies buffer state. The cache re-dirtying a looked-up line produces a fresh eviction later.
- Reset mid-drain: mem_wr_req_o drops the cycle after rst_n is sampled low, and all queued entries are discarded.

Test Plan:
- Single line: push addr 0x0000_1234, data 0xA5..A5 -> mem_wr_req_o=1 next cycle with addr 0x0000_1230, data 0xA5..A5; ack after 3 cycles -> count_o 1->0, empty_o=1, req drops the following cycle.
- Fill: 4 pushes with no ack -> evict_ready_o=0, count_o=4. A 5th push is ignored. One ack -> ready=1 and the 5th push is accepted; drain order equals push order, with the wrap-around verified.
- Simultaneous push+ack at count=2 -> count stays 2, FIFO order preserved, req stays high, and the next head is presented the cycle after the ack.
- Lookup: queue 0x100 (data D1) and 0x200 (D2), then lookup 0x208 -> hit, D2. Lookup 0x300 -> hit=0, data=0. Lookup of the head in its ack cycle -> hit; the cycle after -> miss.
- Duplicate: push 0x400/D1 then 0x400/D2; lookup 0x404 -> D2. Memory receives D1 then D2.
- Reset with 3 entries while REQ is held -> next cycle req=0, count_o=0, empty_o=1, lookup misses; a subsequent push works normally.
